move_target_generator: RTL and testbench
========================================

Name: move_target_generator

Overview:
- Inverse of the move-distance checker: given a piece code and its square, sequentially emits every geometrically reachable target square, one per valid/ready handshake.
- Sits between the game-logic FSM and the board display/highlighter, which consumes candidate targets.
- Board geometry only. Occupancy, blocking and check are filtered downstream.

Parameters:
- None. Board is fixed at 8x8, index = col*8 + row, row 0 at the top, white on the bottom.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request a new enumeration; sampled only in IDLE.
- currentPosition  input  6  source square; latched on accepted start.
- currentPiece  input  4  piece code (bit3 = black; 0 empty, 1 king, 2 queen, 3 bishop, 4 knight, 5 rook, 6 pawn); latched on accepted start.
- targetReady  input  1  consumer accepts targetPosition.
- targetPosition  output  6  candidate target square.
- targetValid  output  1  targetPosition is valid.
- busy  output  1  high from accepted start until done.
- done  output  1  one-cycle pulse after the last target.
- count  output  6  number of targets emitted in the current/last run.

Behaviour:
- Reset (async): state IDLE; targetPosition=0, targetValid=0, busy=0, done=0, count=0. Reset mid-run aborts with no further output.
- States:
  - IDLE: start=1 latches position/piece, clears count, goes to SCAN with busy=1.
  - SCAN: evaluates one candidate per cycle. An on-board candidate goes to EMIT. An off-board candidate is skipped. When candidates are exhausted, go to DONE.
  - EMIT: targetValid=1; targetPosition held stable until targetValid&&targetReady. On that cycle count+1, advance the candidate, return to SCAN.
  - DONE: done=1 for one cycle, busy=0, back to IDLE. count holds until the next start.
- Candidate generation:
  - Split the square into col = pos[5:3] and row = pos[2:0].
  - Candidate = (col+dc, row+dr), computed in signed 5-bit. Off-board iff either coordinate is <0 or >7; no wrap-around is permitted.
- Direction table, in order (dc,dr): d0(-1,-1), d1(0,-1), d2(+1,-1), d3(-1,0), d4(+1,0), d5(-1,+1), d6(0,+1), d7(+1,+1).
- King: d0..d7, single step.
- Queen: d0..d7, sliding.
- Rook: d1,d3,d4,d6, sliding.
- Bishop: d0,d2,d5,d7, sliding.
- Sliding pieces: step 1..7 along a direction. The first off-board step ends that direction and costs one SCAN cycle.
- Knight, in order: (-2,-1), (-2,+1), (-1,-2), (-1,+2), (+1,-2), (+1,+2), (+2,-1), (+2,+1).
- White pawn, in order:
  - (0,-1).
  - (0,-2), only if row==6.
  - (-1,-1), then (+1,-1).
- Black pawn, in order:
  - (0,+1).
  - (0,+2), only if row==1.
  - (-1,+1), then (+1,+1).
- Empty or undefined piece code: SCAN finds no candidates, DONE follows, count=0.
- Latency: start accepted at cycle N gives SCAN at N+1. The first on-board candidate asserts targetValid at N+2. With targetReady held high, each following on-board candidate costs 2 cycles plus 1 per skipped off-board candidate.
- start while busy is ignored. Inputs changing mid-run have no effect, since values are latched.
- targetValid, once asserted, never drops without a handshake (except on reset).

Test Plan:
- White knight @0, targetReady=1 -> targets 10, 17 in that order; count=2; done pulses once.
- White pawn @54 -> 53, 52, 45, 61; count=4. White pawn @53 -> 52, 44, 60; count=3.
- White rook @0 -> 8,16,...,56 then 1,2,...,7; count=14. King @63 -> 54, 62, 55; count=3.
- Queen @27 (col3,row3) -> 27 targets, none repeated, all on-board. Black bishop @7 -> 14,21,28,35,42,49,56; count=7.
- Backpressure: knight @0, targetReady low for 5 cycles after first targetValid -> targetPosition=10 and targetValid stay stable. start pulsed meanwhile is ignored; 17 follows after release.
- Assert reset during EMIT of rook @0 -> outputs go 0 immediately, state IDLE. Next start with empty piece (0) -> done within 3 cycles, count=0, no targetValid.

Source files
------------

// File: rtl/move_target_generator_if.sv
// Handshake bundle between the game-logic FSM and the move target generator.
// The master side requests an enumeration and consumes candidate squares.
// The slave side is the generator itself.
interface move_target_generator_if;
  logic       start;
  logic [5:0] currentPosition;
  logic [3:0] currentPiece;
  logic       targetReady;
  logic [5:0] targetPosition;
  logic       targetValid;
  logic       busy;
  logic       done;
  logic [5:0] count;

  modport master (
    output start, currentPosition, currentPiece, targetReady,
    input  targetPosition, targetValid, busy, done, count
  );

  modport slave (
    input  start, currentPosition, currentPiece, targetReady,
    output targetPosition, targetValid, busy, done, count
  );
endinterface

// File: rtl/move_target_generator.sv
// Move target generator: for a latched piece/square, walks that piece's
// candidate list and emits every on-board target square, one per
// valid/ready handshake. Only board geometry is considered; occupancy,
// blocking and check are filtered further downstream.
// Square index is col*8 + row, with row 0 at the top.
module move_target_generator (
  input  logic                          clk,
  input  logic                          reset,
  move_target_generator_if.slave        bus
);

  typedef enum logic [1:0] {IDLE, SCAN, EMIT, DONE} state_t;

  state_t     state;
  logic [5:0] posReg;
  logic [3:0] pieceReg;
  logic [3:0] idxReg;     // position in the piece's candidate list
  logic [2:0] stepReg;    // distance along a sliding direction (1..7)
  logic [5:0] targetPositionOut;
  logic       targetValidOut;
  logic       busyOut;
  logic       doneOut;
  logic [5:0] countOut;

  // Candidate decode
  logic [3:0]        listLen;
  logic              sliding;
  logic signed [4:0] dc;
  logic signed [4:0] dr;
  logic signed [4:0] stepSigned;
  logic signed [4:0] candCol;
  logic signed [4:0] candRow;
  logic              onBoard;
  logic              exhausted;
  logic              pawnDouble;
  logic [1:0]        pawnIdx;
  logic signed [4:0] pawnFwd;

  // Compass direction table d0..d7, packed as {dc, dr}.
  function automatic logic [9:0] dirDelta(input logic [2:0] d);
    logic signed [4:0] x;
    logic signed [4:0] y;
    x = (d == 3'd0 || d == 3'd3 || d == 3'd5) ? -5'sd1 :
        ((d == 3'd1 || d == 3'd6) ? 5'sd0 : 5'sd1);
    y = (d < 3'd3) ? -5'sd1 : ((d < 3'd5) ? 5'sd0 : 5'sd1);
    return {x, y};
  endfunction

  // Decode the current candidate's offset for the latched piece and test it.
  always_comb begin
    listLen    = 4'd0;
    sliding    = 1'b0;
    dc         = 5'sd0;
    dr         = 5'sd0;
    pawnFwd    = pieceReg[3] ? 5'sd1 : -5'sd1;
    // Double step only from the pawn's home row.
    pawnDouble = pieceReg[3] ? (posReg[2:0] == 3'd1) : (posReg[2:0] == 3'd6);
    // Without the double step the list collapses: entries 1,2 become diagonals.
    pawnIdx    = (!pawnDouble && idxReg[1:0] != 2'd0) ? idxReg[1:0] + 2'd1 : idxReg[1:0];

    case (pieceReg[2:0])
      3'd1: begin  // king
        listLen  = 4'd8;
        {dc, dr} = dirDelta(idxReg[2:0]);
      end
      3'd2: begin  // queen
        listLen  = 4'd8;
        sliding  = 1'b1;
        {dc, dr} = dirDelta(idxReg[2:0]);
      end
      3'd3: begin  // bishop: d0, d2, d5, d7
        listLen = 4'd4;
        sliding = 1'b1;
        case (idxReg[1:0])
          2'd0:    {dc, dr} = dirDelta(3'd0);
          2'd1:    {dc, dr} = dirDelta(3'd2);
          2'd2:    {dc, dr} = dirDelta(3'd5);
          default: {dc, dr} = dirDelta(3'd7);
        endcase
      end
      3'd4: begin  // knight: column offset from bits [2:1], row sign from bit 0
        listLen = 4'd8;
        case (idxReg[2:1])
          2'd0:    dc = -5'sd2;
          2'd1:    dc = -5'sd1;
          2'd2:    dc = 5'sd1;
          default: dc = 5'sd2;
        endcase
        if (idxReg[2:1] == 2'd1 || idxReg[2:1] == 2'd2)
          dr = idxReg[0] ? 5'sd2 : -5'sd2;
        else
          dr = idxReg[0] ? 5'sd1 : -5'sd1;
      end
      3'd5: begin  // rook: d1, d3, d4, d6
        listLen = 4'd4;
        sliding = 1'b1;
        case (idxReg[1:0])
          2'd0:    {dc, dr} = dirDelta(3'd1);
          2'd1:    {dc, dr} = dirDelta(3'd3);
          2'd2:    {dc, dr} = dirDelta(3'd4);
          default: {dc, dr} = dirDelta(3'd6);
        endcase
      end
      3'd6: begin  // pawn: forward, optional double, then both captures
        listLen = pawnDouble ? 4'd4 : 4'd3;
        case (pawnIdx)
          2'd0: begin dc = 5'sd0;  dr = pawnFwd; end
          2'd1: begin dc = 5'sd0;  dr = pieceReg[3] ? 5'sd2 : -5'sd2; end
          2'd2: begin dc = -5'sd1; dr = pawnFwd; end
          default: begin dc = 5'sd1; dr = pawnFwd; end
        endcase
      end
      default: listLen = 4'd0;  // empty or undefined code: nothing to emit
    endcase

    stepSigned = {2'b00, stepReg};
    candCol    = $signed({2'b00, posReg[5:3]}) + dc * stepSigned;
    candRow    = $signed({2'b00, posReg[2:0]}) + dr * stepSigned;
    // In range 0..7 exactly when the sign bit and bit 3 are both clear.
    onBoard    = (candCol[4:3] == 2'b00) && (candRow[4:3] == 2'b00);
    exhausted  = (idxReg >= listLen);
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      posReg            <= 6'd0;
      pieceReg          <= 4'd0;
      idxReg            <= 4'd0;
      stepReg           <= 3'd1;
      targetPositionOut <= 6'd0;
      targetValidOut    <= 1'b0;
      busyOut           <= 1'b0;
      doneOut           <= 1'b0;
      countOut          <= 6'd0;
    end else begin
      case (state)
        IDLE: begin
          doneOut <= 1'b0;
          if (bus.start) begin
            posReg   <= bus.currentPosition;
            pieceReg <= bus.currentPiece;
            idxReg   <= 4'd0;
            stepReg  <= 3'd1;
            countOut <= 6'd0;
            busyOut  <= 1'b1;
            state    <= SCAN;
          end
        end
        SCAN: begin
          if (exhausted) begin
            busyOut <= 1'b0;
            doneOut <= 1'b1;
            state   <= DONE;
          end else if (onBoard) begin
            targetPositionOut <= {candCol[2:0], candRow[2:0]};
            targetValidOut    <= 1'b1;
            state             <= EMIT;
          end else begin
            // Off-board ends a sliding ray, or skips a single-step candidate.
            idxReg  <= idxReg + 4'd1;
            stepReg <= 3'd1;
          end
        end
        EMIT: begin
          if (bus.targetReady) begin
            targetValidOut <= 1'b0;
            countOut       <= countOut + 6'd1;
            state          <= SCAN;
            if (sliding && stepReg != 3'd7) begin
              stepReg <= stepReg + 3'd1;
            end else begin
              idxReg  <= idxReg + 4'd1;
              stepReg <= 3'd1;
            end
          end
        end
        default: begin  // DONE
          doneOut <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign bus.targetPosition = targetPositionOut;
  assign bus.targetValid    = targetValidOut;
  assign bus.busy           = busyOut;
  assign bus.done           = doneOut;
  assign bus.count          = countOut;

endmodule

// File: tb/tb_move_target_generator.sv
// Directed bench for move_target_generator: a table of piece/square vectors
// with hand-computed target lists, plus backpressure and reset sequences.
module tb_move_target_generator;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  move_target_generator_if bus();

  move_target_generator dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0] piece;
    logic [5:0] pos;
    int         off;       // first expected target in expFlat
    int         n;         // number of expected targets
    int         expFirst;  // negedge index of first targetValid, -1 if none
  } vec_t;

  localparam int NV = 11;
  vec_t vecs[NV];
  int   expFlat[67];

  int checks = 0;
  int errors = 0;
  int gotQ[$];
  int firstValidAt;
  int doneAt;
  bit timedOut;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the following negedge (start accepted).
  task automatic startRun(input logic [3:0] pc, input logic [5:0] ps);
    bus.currentPiece    = pc;
    bus.currentPosition = ps;
    bus.start           = 1'b1;
    @(negedge clk);
    bus.start           = 1'b0;
  endtask

  // Collects handshaken targets until done is seen or the budget runs out.
  task automatic collect(input int budget);
    gotQ.delete();
    firstValidAt = -1;
    doneAt       = -1;
    timedOut     = 1'b1;
    for (int i = 1; i <= budget; i++) begin
      if (bus.targetValid && firstValidAt < 0) firstValidAt = i;
      if (bus.done) begin
        doneAt   = i;
        timedOut = 1'b0;
        break;
      end
      if (bus.targetValid && bus.targetReady) gotQ.push_back(int'(bus.targetPosition));
      @(negedge clk);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    int w;
    // Expected target lists, in emission order.
    expFlat = '{
      10, 17,                                           // 0  W knight @0
      53, 52, 45, 61,                                   // 2  W pawn @54
      52, 44, 60,                                       // 6  W pawn @53
      8, 16, 24, 32, 40, 48, 56, 1, 2, 3, 4, 5, 6, 7,   // 9  W rook @0
      54, 62, 55,                                       // 23 W king @63
      18, 9, 0, 26, 25, 24, 34, 41, 48, 19, 11, 3,      // 26 W queen @27
      35, 43, 51, 59, 20, 13, 6, 28, 29, 30, 31,
      36, 45, 54, 63,
      14, 21, 28, 35, 42, 49, 56,                       // 53 B bishop @7
      10, 11, 2, 18,                                    // 60 B pawn @9
      8, 1, 9                                           // 64 B king @0
    };
    vecs[0]  = '{4'd4,  6'd0,  0,  2, 7};
    vecs[1]  = '{4'd6,  6'd54, 2,  4, 2};
    vecs[2]  = '{4'd6,  6'd53, 6,  3, 2};
    vecs[3]  = '{4'd5,  6'd0,  9,  14, 4};
    vecs[4]  = '{4'd1,  6'd63, 23, 3, 2};
    vecs[5]  = '{4'd2,  6'd27, 26, 27, 2};
    vecs[6]  = '{4'd11, 6'd7,  53, 7, 3};
    vecs[7]  = '{4'd14, 6'd9,  60, 4, 2};
    vecs[8]  = '{4'd0,  6'd0,  64, 0, -1};
    vecs[9]  = '{4'd7,  6'd20, 64, 0, -1};
    vecs[10] = '{4'd9,  6'd0,  64, 3, 6};

    bus.start           = 1'b0;
    bus.currentPiece    = 4'd0;
    bus.currentPosition = 6'd0;
    bus.targetReady     = 1'b1;
    reset               = 1'b1;
    repeat (2) @(negedge clk);
    check("reset targetPosition", int'(bus.targetPosition), 0);
    check("reset targetValid", int'(bus.targetValid), 0);
    check("reset busy", int'(bus.busy), 0);
    check("reset done", int'(bus.done), 0);
    check("reset count", int'(bus.count), 0);
    reset = 1'b0;
    @(negedge clk);

    // Table-driven enumeration with targetReady held high.
    for (int v = 0; v < NV; v++) begin
      startRun(vecs[v].piece, vecs[v].pos);
      check($sformatf("v%0d busy after start", v), int'(bus.busy), 1);
      collect(400);
      check($sformatf("v%0d timeout", v), int'(timedOut), 0);
      check($sformatf("v%0d first valid cycle", v), firstValidAt, vecs[v].expFirst);
      check($sformatf("v%0d target count", v), gotQ.size(), vecs[v].n);
      for (int k = 0; k < vecs[v].n; k++) begin
        if (k < gotQ.size())
          check($sformatf("v%0d target%0d", v, k), gotQ[k], expFlat[vecs[v].off + k]);
      end
      check($sformatf("v%0d count", v), int'(bus.count), vecs[v].n);
      check($sformatf("v%0d busy at done", v), int'(bus.busy), 0);
      @(negedge clk);
      check($sformatf("v%0d done one-shot", v), int'(bus.done), 0);
      check($sformatf("v%0d count hold", v), int'(bus.count), vecs[v].n);
      $display("vector %0d piece=%0d pos=%0d targets=%0d count=%0d", v,
               vecs[v].piece, vecs[v].pos, gotQ.size(), bus.count);
    end

    // Backpressure: knight @0, ready low; start pulsed mid-stall is ignored.
    bus.targetReady = 1'b0;
    startRun(4'd4, 6'd0);
    for (w = 0; w < 50 && !bus.targetValid; w++) @(negedge clk);
    check("bp valid seen", int'(bus.targetValid), 1);
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp hold pos c%0d", c), int'(bus.targetPosition), 10);
      check($sformatf("bp hold valid c%0d", c), int'(bus.targetValid), 1);
      if (c == 1) begin
        bus.start           = 1'b1;
        bus.currentPiece    = 4'd5;
        bus.currentPosition = 6'd27;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
    end
    bus.start       = 1'b0;
    check("bp busy during stall", int'(bus.busy), 1);
    bus.targetReady = 1'b1;
    collect(100);
    check("bp timeout", int'(timedOut), 0);
    check("bp target count", gotQ.size(), 2);
    if (gotQ.size() > 0) check("bp target0", gotQ[0], 10);
    if (gotQ.size() > 1) check("bp target1", gotQ[1], 17);
    check("bp count", int'(bus.count), 2);
    repeat (3) @(negedge clk);
    check("bp no restart busy", int'(bus.busy), 0);
    check("bp no restart valid", int'(bus.targetValid), 0);
    $display("backpressure run targets=%0d count=%0d", gotQ.size(), bus.count);

    // Reset during EMIT of rook @0, then an empty-piece run.
    bus.targetReady = 1'b0;
    startRun(4'd5, 6'd0);
    for (w = 0; w < 50 && !bus.targetValid; w++) @(negedge clk);
    check("rst pre valid", int'(bus.targetValid), 1);
    check("rst pre pos", int'(bus.targetPosition), 8);
    #2 reset = 1'b1;
    #1;
    check("rst async targetValid", int'(bus.targetValid), 0);
    check("rst async targetPosition", int'(bus.targetPosition), 0);
    check("rst async busy", int'(bus.busy), 0);
    check("rst async done", int'(bus.done), 0);
    check("rst async count", int'(bus.count), 0);
    @(negedge clk);
    reset           = 1'b0;
    bus.targetReady = 1'b1;
    @(negedge clk);
    check("rst idle valid", int'(bus.targetValid), 0);
    startRun(4'd0, 6'd0);
    collect(3);
    check("empty done within 3", int'(timedOut), 0);
    check("empty done cycle", doneAt, 2);
    check("empty no valid", firstValidAt, -1);
    check("empty count", int'(bus.count), 0);
    $display("post-reset empty run done at %0d count=%0d", doneAt, bus.count);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
